sci_frame_arb: RTL and testbench
================================

SCI_FRAME_ARB -- requirements
Module: sci_frame_arb

Interface
REQ-001 Parameter NCH, default 4: number of science-data FIFO requesters.
REQ-002 Parameter FRAME_LEN, default 32: bytes per frame.
REQ-003 Parameter CNT_W, default 4: width of each per-channel pending-frame counter.
REQ-004 Port clk_in, input, 1: the single clock, 50 MHz.
REQ-005 Port rst_n_in, input, 1: asynchronous, active-low reset.
REQ-006 Port trans_enb_in, input, 1: downlink enable; gates only new grants.
REQ-007 Port frame_rdy_in, input, NCH: one-cycle pulse per channel when its writer completes a frame.
REQ-008 Port fifo_empty_in, input, NCH: per-channel FIFO empty flag.
REQ-009 Port fifo_data_in, input, 8*NCH: per-channel FIFO read data; channel k occupies bits [8k+7:8k].
REQ-010 Port fifo_rd_out, output, NCH: per-channel FIFO read strobe; read data is valid one cycle after the strobe.
REQ-011 Port dl_data_out, input/output direction output, 8: downlink byte.
REQ-012 Port dl_valid_out, output, 1: byte valid.
REQ-013 Port dl_ready_in, input, 1: sink ready.
REQ-014 Port dl_sof_out / dl_eof_out, output, 1 each: first-byte and last-byte markers, qualified by dl_valid_out.
REQ-015 Port dl_chan_out, output, log2(NCH): granted channel, held constant for the whole frame.
REQ-016 Port busy_out, output, 1: high whenever the state is not IDLE.
REQ-017 Port ovf_out, output, NCH: sticky pending-counter overflow flags.
REQ-018 Port ovf_clr_in, input, 1: clears all ovf_out bits.
REQ-019 Port frame_sent_cnt_out, output, 16: count of completed frames; wraps modulo 2^16.

Function
REQ-020 Each channel SHALL keep a pending counter: +1 on frame_rdy_in, -1 on grant.
- Increment and decrement in the same cycle: counter unchanged.
- Increment while at 2^CNT_W-1 with no decrement: counter holds and ovf_out[k] sets.
REQ-021 ovf_out SHALL be sticky until ovf_clr_in; if a new overflow and ovf_clr_in occur in the same cycle, the set wins.
REQ-022 The FSM SHALL have states IDLE, RD, WAIT, SEND, DONE.
REQ-023 IDLE SHALL grant when trans_enb_in=1 and any pending counter is nonzero:
- round-robin, searching from last_grant+1 upward with wrap;
- registers ch, decrements that counter, clears byte_cnt, goes to RD.
REQ-024 RD SHALL assert fifo_rd_out[ch] for exactly one cycle when fifo_empty_in[ch]=0, then go to WAIT; while empty, it stays in RD with no strobe.
REQ-025 WAIT SHALL capture fifo_data_in[ch] into the output holding register, then go to SEND.
REQ-026 SEND SHALL drive dl_valid_out=1 with the held byte.
- dl_sof_out=1 when byte_cnt=0; dl_eof_out=1 when byte_cnt=FRAME_LEN-1.
- On dl_ready_in=1: byte_cnt increments; next state is DONE if byte_cnt=FRAME_LEN-1, else RD.
- With dl_ready_in=0, data and markers hold stable.
REQ-027 DONE SHALL, for one cycle, increment frame_sent_cnt_out, set last_grant=ch, and return to IDLE.
REQ-028 Minimum throughput SHALL be one byte per 3 cycles; minimum frame length in cycles is 3*FRAME_LEN+2.
REQ-029 Frames SHALL be atomic: trans_enb_in falling mid-frame does not abort; no new grant is made while it is low.
REQ-030 fifo_rd_out SHALL be one-hot or zero, and only ever asserted in RD.
REQ-031 dl_valid_out, dl_sof_out and dl_eof_out SHALL be 0 outside SEND.

Reset
REQ-032 While rst_n_in=0, all outputs and counters SHALL be 0, the state SHALL be IDLE, and last_grant SHALL be NCH-1, so channel 0 has first priority.
REQ-033 Reset asserted mid-frame SHALL abandon the frame immediately; pending counts are lost and no eof is emitted.

Verification
REQ-034 Single frame on ch0, dl_ready_in=1: 32 bytes with sof on byte 0 and eof on byte 31, dl_chan_out=0, frame_sent_cnt_out=1, done in 98 cycles from grant.
REQ-035 frame_rdy_in pulsed on ch0..ch3 in the same cycle: grant order 0,1,2,3; then one more pulse each on ch1 and ch3 gives order 1,3.
REQ-036 16 pulses on ch2 with no grants (trans_enb_in=0): counter=15 and ovf_out=4'b0100; ovf_clr_in clears it; a simultaneous pulse and clear leaves it set.
REQ-037 dl_ready_in held low 10 cycles at byte 5: byte 5 is held stable, no extra fifo_rd_out strobe, 32 bytes delivered in total.
REQ-038 trans_enb_in dropped at byte 10: the frame completes, then the FSM stays in IDLE with pending>0 until enable returns.
REQ-039 fifo_empty_in[ch]=1 for 4 cycles while in RD: no strobe, the FSM stays in RD, and it resumes when the flag clears.

Source files
------------

// File: rtl/sci_frame_arb.sv
// sci_frame_arb: round-robin arbiter that drains whole frames from per-channel science FIFOs onto one byte-wide downlink.
// Each byte takes RD/WAIT/SEND (3 cycles min, 3*FRAME_LEN+2 per frame incl. grant and DONE); dl_ready_in low stalls in SEND with data held.
module sci_frame_arb #(
  parameter int NCH       = 4,
  parameter int FRAME_LEN = 32,
  parameter int CNT_W     = 4,
  localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int BC_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 trans_enb_in,
  input  logic [NCH-1:0]       frame_rdy_in,
  input  logic [NCH-1:0]       fifo_empty_in,
  input  logic [8*NCH-1:0]     fifo_data_in,
  output logic [NCH-1:0]       fifo_rd_out,
  output logic [7:0]           dl_data_out,
  output logic                 dl_valid_out,
  input  logic                 dl_ready_in,
  output logic                 dl_sof_out,
  output logic                 dl_eof_out,
  output logic [CH_W-1:0]      dl_chan_out,
  output logic                 busy_out,
  output logic [NCH-1:0]       ovf_out,
  input  logic                 ovf_clr_in,
  output logic [15:0]          frame_sent_cnt_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t           state;
  logic [CH_W-1:0]  ch;
  logic [CH_W-1:0]  last_grant;
  logic [BC_W-1:0]  byte_cnt;
  logic [7:0]       hold;
  logic [CNT_W-1:0] pend [NCH];

  logic             gnt_found;
  logic [CH_W-1:0]  gnt_idx;
  logic             grant;
  logic [NCH-1:0]   dec_vec;
  logic [NCH-1:0]   ovf_set;
  logic             last_byte;
  logic [7:0]       sel_data;

  // Round-robin search starting just after the previously served channel.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 1; i <= NCH; i++) begin
      idx = (int'(last_grant) + i) % NCH;
      if (!gnt_found && pend[idx] != '0) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(idx);
      end
    end
  end

  assign grant = (state == S_IDLE) && trans_enb_in && gnt_found;

  always_comb begin
    dec_vec = '0;
    if (grant) dec_vec[gnt_idx] = 1'b1;
  end

  always_comb begin
    ovf_set = '0;
    for (int k = 0; k < NCH; k++) begin
      ovf_set[k] = frame_rdy_in[k] && !dec_vec[k] && (pend[k] == '1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NCH; k++) pend[k] <= '0;
      ovf_out <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (frame_rdy_in[k] && !dec_vec[k]) begin
          if (pend[k] != '1) pend[k] <= pend[k] + CNT_W'(1);
        end else if (dec_vec[k] && !frame_rdy_in[k]) begin
          pend[k] <= pend[k] - CNT_W'(1);
        end
      end
      // A fresh overflow in the clearing cycle survives the clear.
      ovf_out <= (ovf_out & ~{NCH{ovf_clr_in}}) | ovf_set;
    end
  end

  assign last_byte = (byte_cnt == BC_W'(FRAME_LEN - 1));
  assign sel_data  = fifo_data_in[ch*8 +: 8];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= S_IDLE;
      ch                 <= '0;
      last_grant         <= CH_W'(NCH - 1);
      byte_cnt           <= '0;
      hold               <= '0;
      frame_sent_cnt_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            ch       <= gnt_idx;
            byte_cnt <= '0;
            state    <= S_RD;
          end
        end
        S_RD: begin
          if (!fifo_empty_in[ch]) state <= S_WAIT;
        end
        S_WAIT: begin
          hold  <= sel_data;
          state <= S_SEND;
        end
        S_SEND: begin
          if (dl_ready_in) begin
            byte_cnt <= byte_cnt + BC_W'(1);
            state    <= last_byte ? S_DONE : S_RD;
          end
        end
        S_DONE: begin
          frame_sent_cnt_out <= frame_sent_cnt_out + 16'd1;
          last_grant         <= ch;
          state              <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_rd_out = '0;
    if (state == S_RD && !fifo_empty_in[ch]) fifo_rd_out[ch] = 1'b1;
  end

  assign dl_data_out  = hold;
  assign dl_valid_out = (state == S_SEND);
  assign dl_sof_out   = (state == S_SEND) && (byte_cnt == '0);
  assign dl_eof_out   = (state == S_SEND) && last_byte;
  assign dl_chan_out  = ch;
  assign busy_out     = (state != S_IDLE);

  a_rd_onehot: assert property (@(posedge clk_in) disable iff (!rst_n_in) $onehot0(fifo_rd_out));
  a_rd_in_rd:  assert property (@(posedge clk_in) disable iff (!rst_n_in) (fifo_rd_out != '0) |-> (state == S_RD));

endmodule

// File: tb/tb_sci_frame_arb.sv
// Bench for sci_frame_arb: a frame-level model predicts grants, byte content and counters; directed scenarios pin it.
module tb_sci_frame_arb;
  localparam int NCH = 4;
  localparam int FL  = 32;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic             trans_enb_in;
  logic [NCH-1:0]   frame_rdy_in;
  logic [NCH-1:0]   fifo_empty_in;
  logic [8*NCH-1:0] fifo_data_in;
  logic [NCH-1:0]   fifo_rd_out;
  logic [7:0]       dl_data_out;
  logic             dl_valid_out;
  logic             dl_ready_in;
  logic             dl_sof_out;
  logic             dl_eof_out;
  logic [1:0]       dl_chan_out;
  logic             busy_out;
  logic [NCH-1:0]   ovf_out;
  logic             ovf_clr_in;
  logic [15:0]      frame_sent_cnt_out;

  sci_frame_arb #(.NCH(NCH), .FRAME_LEN(FL), .CNT_W(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .trans_enb_in(trans_enb_in),
    .frame_rdy_in(frame_rdy_in), .fifo_empty_in(fifo_empty_in), .fifo_data_in(fifo_data_in),
    .fifo_rd_out(fifo_rd_out), .dl_data_out(dl_data_out), .dl_valid_out(dl_valid_out),
    .dl_ready_in(dl_ready_in), .dl_sof_out(dl_sof_out), .dl_eof_out(dl_eof_out),
    .dl_chan_out(dl_chan_out), .busy_out(busy_out), .ovf_out(ovf_out),
    .ovf_clr_in(ovf_clr_in), .frame_sent_cnt_out(frame_sent_cnt_out)
  );

  always #10 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int k, input int n);
    return 8'((k << 6) + n * 5 + 3);
  endfunction

  // Bench-side FIFOs: data appears the cycle after a strobe.
  logic [NCH-1:0] s_rd = '0;
  int fptr [NCH];
  always @(posedge clk_in) begin
    #1;
    if (!rst_n_in) begin
      for (int k = 0; k < NCH; k++) fptr[k] = 0;
      fifo_data_in = '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (s_rd[k]) begin
          fifo_data_in[8*k +: 8] = pat(k, fptr[k]);
          fptr[k]++;
        end
      end
    end
  end

  // Frame-level model state.
  int          pend_m [NCH];
  logic [NCH-1:0] ovf_m;
  int          lastg_m, cur_m, nbyte_m, nstrobe_m, sent_m;
  int          cons_m [NCH];
  bit          in_frame, done_nxt, prev_stall;
  int          sof_cnt, eof_cnt;
  logic [7:0]  first_b, last_b;
  int          order_q [$];

  always @(negedge clk_in) begin
    int pick, c;
    logic [NCH-1:0] set_v;
    s_rd = fifo_rd_out;
    if (!rst_n_in) begin
      check("rst_rd", fifo_rd_out, 0);
      check("rst_valid", dl_valid_out, 0);
      check("rst_sof_eof", {dl_sof_out, dl_eof_out}, 0);
      check("rst_busy", busy_out, 0);
      check("rst_ovf", ovf_out, 0);
      check("rst_sent", frame_sent_cnt_out, 0);
      check("rst_chan", dl_chan_out, 0);
      check("rst_data", dl_data_out, 0);
      for (int k = 0; k < NCH; k++) begin pend_m[k] = 0; cons_m[k] = 0; end
      ovf_m = '0; lastg_m = NCH - 1; cur_m = 0; nbyte_m = 0; nstrobe_m = 0;
      sent_m = 0; in_frame = 0; done_nxt = 0; prev_stall = 0;
    end else begin
      check("rd_onehot", $onehot0(fifo_rd_out), 1);
      check("rd_while_empty", fifo_rd_out & fifo_empty_in, 0);
      check("rd_outside_frame", (fifo_rd_out != 0) && !in_frame, 0);
      check("busy", busy_out, in_frame);
      check("ovf", ovf_out, ovf_m);
      check("sent_cnt", frame_sent_cnt_out, sent_m & 32'hFFFF);
      if (prev_stall) check("stall_valid_held", dl_valid_out, 1);
      if (!dl_valid_out) begin
        check("idle_sof_eof", {dl_sof_out, dl_eof_out}, 0);
      end else begin
        check("valid_in_frame", in_frame && !done_nxt, 1);
        check("chan", dl_chan_out, cur_m);
        check("data", dl_data_out, pat(cur_m, cons_m[cur_m]));
        check("sof", dl_sof_out, nbyte_m == 0);
        check("eof", dl_eof_out, nbyte_m == FL - 1);
      end

      // Advance the model across the coming rising edge.
      prev_stall = dl_valid_out && !dl_ready_in;
      if (fifo_rd_out != 0) nstrobe_m++;
      pick = -1;
      if (!in_frame) begin
        if (trans_enb_in) begin
          for (int j = 1; j <= NCH; j++) begin
            c = (lastg_m + j) % NCH;
            if (pick < 0 && pend_m[c] > 0) pick = c;
          end
          if (pick >= 0) begin
            in_frame = 1; cur_m = pick; nbyte_m = 0; nstrobe_m = 0;
          end
        end
      end else if (done_nxt) begin
        check("strobes_per_frame", nstrobe_m, FL);
        in_frame = 0; done_nxt = 0; sent_m++; lastg_m = cur_m;
      end else if (dl_valid_out && dl_ready_in) begin
        if (nbyte_m == 0) begin order_q.push_back(int'(dl_chan_out)); first_b = dl_data_out; end
        if (dl_sof_out) sof_cnt++;
        if (dl_eof_out) eof_cnt++;
        last_b = dl_data_out;
        cons_m[cur_m]++;
        nbyte_m++;
        if (nbyte_m == FL) done_nxt = 1;
      end
      set_v = '0;
      for (int k = 0; k < NCH; k++) begin
        if (frame_rdy_in[k] && pick != k) begin
          if (pend_m[k] == 15) set_v[k] = 1'b1;
          else pend_m[k]++;
        end else if (pick == k && !frame_rdy_in[k]) begin
          pend_m[k]--;
        end
      end
      ovf_m = (ovf_m & ~{NCH{ovf_clr_in}}) | set_v;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse(input logic [NCH-1:0] m);
    frame_rdy_in = m;
    tick();
    frame_rdy_in = '0;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; trans_enb_in = 1'b0; frame_rdy_in = '0; fifo_empty_in = '0;
    dl_ready_in = 1'b1; ovf_clr_in = 1'b0;
    repeat (3) tick();
    rst_n_in = 1'b1;
    order_q.delete(); sof_cnt = 0; eof_cnt = 0;
    tick();
  endtask

  task automatic wait_sent(input int target, input string name);
    for (int i = 0; i < 3000 && int'(frame_sent_cnt_out) < target; i++) tick();
    check(name, frame_sent_cnt_out, target);
  endtask

  task automatic wait_byte(input int target, input string name);
    for (int i = 0; i < 1000 && nbyte_m != target; i++) tick();
    check(name, nbyte_m, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt, vcnt, rcnt, eof0;
    logic [7:0] sdat;
    do_reset();

    // Single frame on ch0: 97 busy cycles plus the IDLE grant cycle = 98.
    trans_enb_in = 1'b1;
    pulse(4'b0001);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (busy_out) cnt++;
      else if (cnt > 0) break;
    end
    check("t1_busy_cycles", cnt, 97);
    check("t1_sent", frame_sent_cnt_out, 1);
    check("t1_sof_cnt", sof_cnt, 1);
    check("t1_eof_cnt", eof_cnt, 1);
    check("t1_bytes", nbyte_m, 32);
    check("t1_first_byte", first_b, 8'd3);
    check("t1_last_byte", last_b, 8'd158);
    check("t1_chan", order_q[0], 0);

    // Simultaneous requests from reset priority, then ch1+ch3.
    do_reset();
    pulse(4'b1111);
    trans_enb_in = 1'b1;
    wait_sent(4, "t2_sent4");
    pulse(4'b1010);
    wait_sent(6, "t2_sent6");
    check("t2_order_n", order_q.size(), 6);
    check("t2_order0", order_q[0], 0);
    check("t2_order1", order_q[1], 1);
    check("t2_order2", order_q[2], 2);
    check("t2_order3", order_q[3], 3);
    check("t2_order4", order_q[4], 1);
    check("t2_order5", order_q[5], 3);

    // Pending counter saturation and sticky overflow on ch2.
    do_reset();
    for (int i = 0; i < 15; i++) begin pulse(4'b0100); tick(); end
    check("t3_pend_at15", dut.pend[2], 15);
    check("t3_ovf_at15", ovf_out, 4'b0000);
    pulse(4'b0100);
    check("t3_pend_sat", dut.pend[2], 15);
    check("t3_ovf_set", ovf_out, 4'b0100);
    ovf_clr_in = 1'b1; tick(); ovf_clr_in = 1'b0;
    check("t3_ovf_clr", ovf_out, 4'b0000);
    ovf_clr_in = 1'b1; pulse(4'b0100); ovf_clr_in = 1'b0;
    check("t3_ovf_set_wins", ovf_out, 4'b0100);

    // Downlink stall at byte 5 of a ch1 frame.
    do_reset();
    trans_enb_in = 1'b1;
    pulse(4'b0010);
    wait_byte(5, "t4_reach5");
    dl_ready_in = 1'b0;
    vcnt = 0; rcnt = 0; sdat = '0;
    repeat (10) begin
      #1;
      if (dl_valid_out) begin
        if (vcnt == 0) sdat = dl_data_out;
        vcnt++;
      end
      if (fifo_rd_out != 0) rcnt++;
      tick();
    end
    dl_ready_in = 1'b1;
    check("t4_stall_byte", sdat, 8'd92);
    check("t4_valid_cycles", vcnt, 8);
    check("t4_strobes_in_stall", rcnt, 1);
    wait_sent(1, "t4_sent");
    check("t4_bytes", nbyte_m, 32);

    // Enable dropped mid-frame: frame finishes, ch2 waits for enable.
    do_reset();
    pulse(4'b0101);
    trans_enb_in = 1'b1;
    wait_byte(10, "t5_reach10");
    trans_enb_in = 1'b0;
    wait_sent(1, "t5_sent1");
    cnt = 0;
    repeat (20) begin tick(); if (busy_out) cnt++; end
    check("t5_idle_while_off", cnt, 0);
    check("t5_pend2", dut.pend[2], 1);
    trans_enb_in = 1'b1;
    wait_sent(2, "t5_sent2");
    check("t5_order0", order_q[0], 0);
    check("t5_order1", order_q[1], 2);

    // FIFO empty for 4 cycles while waiting to read byte 3 of ch3.
    do_reset();
    trans_enb_in = 1'b1;
    pulse(4'b1000);
    wait_byte(3, "t6_reach3");
    fifo_empty_in = 4'b1000;
    repeat (4) begin
      #1;
      check("t6_no_strobe", fifo_rd_out, 4'b0000);
      check("t6_busy", busy_out, 1);
      check("t6_no_valid", dl_valid_out, 0);
      tick();
    end
    fifo_empty_in = 4'b0000;
    #1;
    check("t6_resume_strobe", fifo_rd_out, 4'b1000);
    wait_sent(1, "t6_sent");

    // Reset mid-frame abandons the frame and all pending requests.
    do_reset();
    trans_enb_in = 1'b1;
    pulse(4'b0011);
    wait_byte(7, "t7_reach7");
    eof0 = eof_cnt;
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    cnt = 0;
    repeat (10) begin tick(); if (busy_out) cnt++; end
    check("t7_no_restart", cnt, 0);
    check("t7_no_eof", eof_cnt, eof0);
    check("t7_sent", frame_sent_cnt_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
